// File: rtl/data_ram_pkg.sv
// Shared encodings for the byte-lane data memory.
package data_ram_pkg;

    // Access size as carried on i_data_size
    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    // Post-reset sequencer state
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Number of 8-bit lanes for a given data path width
    function automatic int unsigned lane_count(input int unsigned bit_width);
        return bit_width / 8;
    endfunction

endpackage

// File: rtl/ram_lane_r1.sv
// One 8-bit wide synchronous single-port RAM lane; read data registered.
module ram_lane_r1 #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned IDX_W = $clog2(WORDS)
) (
    input  logic             i_clk,
    input  logic [7:0]       i_data,
    input  logic [IDX_W-1:0] i_addr,
    input  logic             i_wren,
    output logic [7:0]       o_q
);

    logic [7:0] r_mem [WORDS];
    logic [7:0] r_q;

    // Write when enabled; always register the addressed location for reads
    always_ff @(posedge i_clk) begin
        if (i_wren) begin
            r_mem[i_addr] <= i_data;
        end
        r_q <= r_mem[i_addr];
    end

    assign o_q = r_q;

endmodule

// File: rtl/data_ram_r1.sv
// Byte-lane data memory for the load/store stage: sized, aligned accesses with
// sign/zero extended loads, misalignment fault reporting and a post-reset clear.
module data_ram_r1 import data_ram_pkg::*; #(
    parameter int unsigned BIT_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    output logic                  o_ready,
    input  logic                  i_wren,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [BIT_WIDTH-1:0]  i_data,
    input  logic [1:0]            i_data_size,
    input  logic                  i_is_signed,
    output logic [BIT_WIDTH-1:0]  o_q,
    output logic                  o_rvalid,
    output logic                  o_fault,
    output logic [ADDR_WIDTH-1:0] o_fault_addr
);

    localparam int unsigned LANES     = lane_count(BIT_WIDTH);
    localparam int unsigned LANE_BITS = $clog2(LANES);
    localparam int unsigned IDX_W     = ADDR_WIDTH - LANE_BITS;
    localparam int unsigned WORDS     = 2 ** IDX_W;

    state_e                r_state;
    state_e                w_state_d;
    logic [IDX_W-1:0]      r_clr_cnt;
    logic                  w_clear;

    size_e                 w_size;
    logic [LANE_BITS-1:0]  w_off;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_lane_addr;
    logic                  w_misaligned;
    logic                  w_accept;
    logic                  w_store;
    logic                  w_load;
    logic [LANES-1:0]      w_lane_en;
    logic [BIT_WIDTH-1:0]  w_wdata;
    logic [BIT_WIDTH-1:0]  w_rdata;

    logic                  r_rvalid;
    logic                  r_fault;
    logic [ADDR_WIDTH-1:0] r_fault_addr;
    logic [LANE_BITS-1:0]  r_off;
    size_e                 r_size;
    logic                  r_signed;
    logic [BIT_WIDTH-1:0]  r_q_hold;

    logic [BIT_WIDTH-1:0]  w_shift;
    logic [BIT_WIDTH-1:0]  w_ext;
    logic                  w_sign;
    int                    w_keep_bits;

    // State register and clear counter; reset restarts the clear from word 0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_clear) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // Next state: leave CLEAR once the last word (counter all ones) is written
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            ST_CLEAR: if (&r_clr_cnt) w_state_d = ST_RUN;
            ST_RUN:   w_state_d = ST_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_clear = (r_state == ST_CLEAR);
        o_ready = (r_state == ST_RUN);
    end

    // Request decode: effective size (dword is a word on 32-bit builds) and alignment
    always_comb begin
        w_size = size_e'(i_data_size);
        if (BIT_WIDTH == 32 && w_size == SZ_DWORD) begin
            w_size = SZ_WORD;
        end
        unique case (w_size)
            SZ_BYTE:  w_misaligned = 1'b0;
            SZ_HALF:  w_misaligned = i_addr[0];
            SZ_WORD:  w_misaligned = |i_addr[1:0];
            SZ_DWORD: w_misaligned = |i_addr[2:0];
        endcase
    end

    assign w_off       = i_addr[LANE_BITS-1:0];
    assign w_idx       = i_addr[ADDR_WIDTH-1:LANE_BITS];
    assign w_accept    = i_req && o_ready && !i_rst;
    assign w_store     = w_accept && i_wren && !w_misaligned;
    assign w_load      = w_accept && !i_wren && !w_misaligned;
    assign w_wdata     = i_data << {w_off, 3'b000};
    assign w_lane_addr = w_clear ? r_clr_cnt : w_idx;

    // Lanes covered by the access: offset .. offset + size_bytes - 1
    always_comb begin
        w_lane_en = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            w_lane_en[l] = (l >= int'(w_off)) && (l < int'(w_off) + (1 << w_size));
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic       w_lane_we;
        logic [7:0] w_lane_din;

        assign w_lane_we  = w_clear || (w_store && w_lane_en[l]);
        assign w_lane_din = w_clear ? 8'h00 : w_wdata[8*l +: 8];

        ram_lane_r1 #(
            .WORDS (WORDS),
            .IDX_W (IDX_W)
        ) u_lane (
            .i_clk  (i_clk),
            .i_data (w_lane_din),
            .i_addr (w_lane_addr),
            .i_wren (w_lane_we),
            .o_q    (w_rdata[8*l +: 8])
        );
    end

    // Request pipeline: load attributes travel with the RAM read; faults latch the address
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rvalid     <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
            r_off        <= '0;
            r_size       <= SZ_BYTE;
            r_signed     <= 1'b0;
        end else begin
            r_rvalid <= w_load;
            r_fault  <= w_accept && w_misaligned;
            if (w_accept && w_misaligned) begin
                r_fault_addr <= i_addr;
            end
            if (w_load) begin
                r_off    <= w_off;
                r_size   <= w_size;
                r_signed <= i_is_signed;
            end
        end
    end

    // Right-justify the read word and extend above the access width
    always_comb begin
        w_shift = w_rdata >> {r_off, 3'b000};
        unique case (r_size)
            SZ_BYTE:  begin w_keep_bits = 8;               w_sign = w_shift[7];           end
            SZ_HALF:  begin w_keep_bits = 16;              w_sign = w_shift[15];          end
            SZ_WORD:  begin w_keep_bits = 32;              w_sign = w_shift[31];          end
            SZ_DWORD: begin w_keep_bits = int'(BIT_WIDTH); w_sign = w_shift[BIT_WIDTH-1]; end
        endcase
        w_sign = w_sign && r_signed;
        w_ext  = '0;
        for (int i = 0; i < int'(BIT_WIDTH); i++) begin
            w_ext[i] = (i < w_keep_bits) ? w_shift[i] : w_sign;
        end
    end

    // Hold the last load result while no new one is valid
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q_hold <= '0;
        end else if (r_rvalid) begin
            r_q_hold <= w_ext;
        end
    end

    assign o_q          = r_rvalid ? w_ext : r_q_hold;
    assign o_rvalid     = r_rvalid;
    assign o_fault      = r_fault;
    assign o_fault_addr = r_fault_addr;

endmodule
